rst_sync_pipe_bank: RTL and testbench

- Parametrised, multi-lane successor to a single async-reset flop.
- Contains an internal reset synchroniser: reset asserts asynchronously and deasserts synchronously.
- Contains a DEPTH-stage elastic valid/ready register pipeline carrying CHANNELS lanes of WIDTH bits, with an occupancy counter.
- Sits between fabric blocks that need a registered, back-pressurable, cleanly reset data path on a single clock.

---
 rtl/rst_sync_pipe_bank.sv | 127 ++++++++++++
 tb/tb_rst_sync_pipe_bank.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rst_sync_pipe_bank.sv
// Multi-lane elastic valid/ready register pipeline with a built-in reset synchroniser.
// Reset asserts asynchronously on A_RST and releases synchronously after SYNC_STAGES clocks.
module rst_sync_pipe_bank #(
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       CHANNELS    = 2,
    parameter int unsigned       DEPTH       = 2,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL   = {WIDTH{1'b0}}
) (
    input  logic                           A_CLK,
    input  logic                           A_RST,
    input  logic                           in_valid,
    input  logic [CHANNELS*WIDTH-1:0]      in_data,
    output logic                           in_ready,
    output logic                           out_valid,
    output logic [CHANNELS*WIDTH-1:0]      out_data,
    input  logic                           out_ready,
    output logic                           rst_done,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned BW = CHANNELS * WIDTH;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [BW-1:0] BEAT_RST = {CHANNELS{RESET_VAL}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0]   sync_q;
    logic [SYNC_STAGES-1:0]   sync_d;
    logic                     rst_done_s;

    logic [DEPTH-1:0]         vld_q;
    logic [DEPTH-1:0]         vld_d;
    logic [DEPTH-1:0][BW-1:0] data_q;
    logic [DEPTH-1:0][BW-1:0] data_d;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            count_d;
    logic [DEPTH-1:0]         load_s;
    logic                     in_ready_s;
    logic                     accept_s;
    logic                     xfer_out_s;

    // Release shift: a 1 walks toward the last flop once A_RST is low.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    // Reset synchroniser flops, cleared asynchronously by A_RST.
    always_ff @(posedge A_CLK or posedge A_RST) begin
        if (A_RST) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_done_s = sync_q[SYNC_STAGES-1];

    // Stage k may load when any stage at or beyond k is empty, or downstream takes a beat.
    always_comb begin
        load_s = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            load_s[k] = out_ready;
            for (int j = k; j < DEPTH; j++) begin
                load_s[k] = load_s[k] | ~vld_q[j];
            end
        end
    end

    assign in_ready_s = rst_done_s & load_s[0];
    assign accept_s   = in_valid & in_ready_s;
    assign xfer_out_s = vld_q[DEPTH-1] & out_ready;

    // Next-state for every stage: shift forward where allowed, otherwise hold.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (load_s[0]) begin
            vld_d[0] = accept_s;
            if (accept_s) begin
                data_d[0] = in_data;
            end else begin
                data_d[0] = data_q[0];
            end
        end else begin
            vld_d[0]  = vld_q[0];
            data_d[0] = data_q[0];
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (load_s[k]) begin
                vld_d[k]  = vld_q[k-1];
                data_d[k] = data_q[k-1];
            end else begin
                vld_d[k]  = vld_q[k];
                data_d[k] = data_q[k];
            end
        end
    end

    // Occupancy: moves only when exactly one of accept / output transfer happens.
    always_comb begin
        case ({accept_s, xfer_out_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pipeline state; the synchroniser output is the reset, so a fall of rst_done clears it at once.
    always_ff @(posedge A_CLK or negedge rst_done_s) begin
        if (!rst_done_s) begin
            vld_q   <= {DEPTH{1'b0}};
            data_q  <= {DEPTH{BEAT_RST}};
            count_q <= {CW{1'b0}};
        end else begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign rst_done  = rst_done_s;
    assign count     = count_q;

endmodule

// File: tb/tb_rst_sync_pipe_bank.sv
// Directed, table-driven bench for rst_sync_pipe_bank: default build plus two parameter variants
// sharing one stimulus stream.
module tb_rst_sync_pipe_bank;

    logic        A_CLK     = 1'b0;
    logic        A_RST     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [15:0] in_data   = 16'h0000;
    logic        out_ready = 1'b0;

    logic        ir0, ov0, done0;
    logic [15:0] od0;
    logic [1:0]  cnt0;
    logic        ir1, ov1, done1;
    logic [3:0]  od1;
    logic [0:0]  cnt1;
    logic        ir2, ov2, done2;
    logic [15:0] od2;
    logic [2:0]  cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 A_CLK = ~A_CLK;

    rst_sync_pipe_bank u_dut (
        .A_CLK(A_CLK), .A_RST(A_RST), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
        .rst_done(done0), .count(cnt0)
    );

    rst_sync_pipe_bank #(.WIDTH(1), .CHANNELS(4), .DEPTH(1), .SYNC_STAGES(2)) u_p1 (
        .A_CLK(A_CLK), .A_RST(A_RST), .in_valid(in_valid), .in_data(in_data[3:0]),
        .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ready(out_ready),
        .rst_done(done1), .count(cnt1)
    );

    rst_sync_pipe_bank #(.WIDTH(8), .CHANNELS(2), .DEPTH(4), .SYNC_STAGES(3),
                         .RESET_VAL(8'h5A)) u_p2 (
        .A_CLK(A_CLK), .A_RST(A_RST), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_ready(out_ready),
        .rst_done(done2), .count(cnt2)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [15:0] e_od;
        logic [1:0]  e_cnt;
        logic        e_done;
    } vec_t;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        a_ir;
        logic        a_ov;
        logic [3:0]  a_od;
        logic [0:0]  a_cnt;
        logic        a_done;
        logic        b_ir;
        logic        b_ov;
        logic [15:0] b_od;
        logic [2:0]  b_cnt;
        logic        b_done;
    } sw_t;

    vec_t tv[32];
    sw_t  sv[17];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply_main(input int i);
        @(negedge A_CLK);
        A_RST     = tv[i].rst;
        in_valid  = tv[i].iv;
        in_data   = tv[i].d;
        out_ready = tv[i].ordy;
        #1;
        chk("in_ready",  i, 32'(ir0),   32'(tv[i].e_ir));
        chk("out_valid", i, 32'(ov0),   32'(tv[i].e_ov));
        chk("count",     i, 32'(cnt0),  32'(tv[i].e_cnt));
        chk("rst_done",  i, 32'(done0), 32'(tv[i].e_done));
        if (tv[i].e_ov || !tv[i].e_done) begin
            chk("out_data", i, 32'(od0), 32'(tv[i].e_od));
        end
    endtask

    task automatic apply_sweep(input int i);
        @(negedge A_CLK);
        A_RST     = sv[i].rst;
        in_valid  = sv[i].iv;
        in_data   = sv[i].d;
        out_ready = sv[i].ordy;
        #1;
        chk("p1_in_ready",  i, 32'(ir1),   32'(sv[i].a_ir));
        chk("p1_out_valid", i, 32'(ov1),   32'(sv[i].a_ov));
        chk("p1_count",     i, 32'(cnt1),  32'(sv[i].a_cnt));
        chk("p1_rst_done",  i, 32'(done1), 32'(sv[i].a_done));
        if (sv[i].a_ov || !sv[i].a_done) begin
            chk("p1_out_data", i, 32'(od1), 32'(sv[i].a_od));
        end
        chk("p2_in_ready",  i, 32'(ir2),   32'(sv[i].b_ir));
        chk("p2_out_valid", i, 32'(ov2),   32'(sv[i].b_ov));
        chk("p2_count",     i, 32'(cnt2),  32'(sv[i].b_cnt));
        chk("p2_rst_done",  i, 32'(done2), 32'(sv[i].b_done));
        if (sv[i].b_ov || !sv[i].b_done) begin
            chk("p2_out_data", i, 32'(od2), 32'(sv[i].b_od));
        end
    endtask

    initial begin
        // rst, iv, data, out_ready | in_ready, out_valid, out_data, count, rst_done
        tv[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};
        // streaming
        tv[6]  = '{1'b0, 1'b1, 16'h0101, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};
        tv[7]  = '{1'b0, 1'b1, 16'h0202, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b1};
        tv[8]  = '{1'b0, 1'b1, 16'h0303, 1'b1, 1'b1, 1'b1, 16'h0101, 2'd2, 1'b1};
        tv[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0202, 2'd2, 1'b1};
        tv[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0303, 2'd1, 1'b1};
        tv[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};
        // fill and stall
        tv[12] = '{1'b0, 1'b1, 16'hAA55, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};
        tv[13] = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b1};
        tv[14] = '{1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hAA55, 2'd2, 1'b1};
        tv[15] = '{1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'hAA55, 2'd2, 1'b1};
        tv[16] = '{1'b0, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b1, 16'hAA55, 2'd2, 1'b1};
        tv[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1234, 2'd2, 1'b1};
        tv[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hBEEF, 2'd1, 1'b1};
        tv[19] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};
        // full with simultaneous in/out
        tv[20] = '{1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};
        tv[21] = '{1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b1};
        tv[22] = '{1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 16'h1111, 2'd2, 1'b1};
        tv[23] = '{1'b0, 1'b1, 16'h4444, 1'b1, 1'b1, 1'b1, 16'h2222, 2'd2, 1'b1};
        tv[24] = '{1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 16'h3333, 2'd2, 1'b1};
        tv[25] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h3333, 2'd2, 1'b1};
        // after a short mid-stream reset pulse
        tv[26] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0};
        tv[27] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};
        tv[28] = '{1'b0, 1'b1, 16'hCAFE, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};
        tv[29] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd1, 1'b1};
        tv[30] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hCAFE, 2'd1, 1'b1};
        tv[31] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1};

        // rst, iv, data, out_ready | p1: ir, ov, od, cnt, done | p2: ir, ov, od, cnt, done
        sv[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'd0, 1'b0, 1'b0, 1'b0, 16'h5A5A, 3'd0, 1'b0};
        sv[1]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'd0, 1'b0, 1'b0, 1'b0, 16'h5A5A, 3'd0, 1'b0};
        sv[2]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'd0, 1'b0, 1'b0, 1'b0, 16'h5A5A, 3'd0, 1'b0};
        sv[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'd0, 1'b1, 1'b0, 1'b0, 16'h5A5A, 3'd0, 1'b0};
        sv[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 4'h0, 1'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1};
        sv[5]  = '{1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 4'h0, 1'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1};
        sv[6]  = '{1'b0, 1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 4'h1, 1'd1, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd1, 1'b1};
        sv[7]  = '{1'b0, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 4'h1, 1'd1, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd2, 1'b1};
        sv[8]  = '{1'b0, 1'b1, 16'h4444, 1'b0, 1'b0, 1'b1, 4'h1, 1'd1, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd3, 1'b1};
        sv[9]  = '{1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 4'h1, 1'd1, 1'b1, 1'b0, 1'b1, 16'h1111, 3'd4, 1'b1};
        sv[10] = '{1'b0, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b1, 4'h1, 1'd1, 1'b1, 1'b1, 1'b1, 16'h1111, 3'd4, 1'b1};
        sv[11] = '{1'b0, 1'b1, 16'h6666, 1'b1, 1'b1, 1'b1, 4'h5, 1'd1, 1'b1, 1'b1, 1'b1, 16'h2222, 3'd4, 1'b1};
        sv[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 4'h6, 1'd1, 1'b1, 1'b1, 1'b1, 16'h3333, 3'd4, 1'b1};
        sv[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'h0, 1'd0, 1'b1, 1'b1, 1'b1, 16'h4444, 3'd3, 1'b1};
        sv[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'h0, 1'd0, 1'b1, 1'b1, 1'b1, 16'h5555, 3'd2, 1'b1};
        sv[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'h0, 1'd0, 1'b1, 1'b1, 1'b1, 16'h6666, 3'd1, 1'b1};
        sv[16] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'h0, 1'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b1};

        for (int i = 0; i < 26; i++) begin
            apply_main(i);
        end

        // Pipeline is full; pulse A_RST for less than a clock, between edges.
        @(negedge A_CLK);
        #1;
        chk("pre_pulse_valid", 100, 32'(ov0),  32'(1'b1));
        chk("pre_pulse_count", 100, 32'(cnt0), 32'(2'd2));
        chk("pre_pulse_data",  100, 32'(od0),  32'(16'h3333));
        #1;
        A_RST = 1'b1;
        #1;
        chk("pulse_valid", 101, 32'(ov0),   32'(1'b0));
        chk("pulse_count", 101, 32'(cnt0),  32'(2'd0));
        chk("pulse_data",  101, 32'(od0),   32'(16'h0000));
        chk("pulse_done",  101, 32'(done0), 32'(1'b0));
        chk("pulse_ready", 101, 32'(ir0),   32'(1'b0));
        #1;
        A_RST = 1'b0;

        for (int i = 26; i < 32; i++) begin
            apply_main(i);
        end

        for (int i = 0; i < 17; i++) begin
            apply_sweep(i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
